// File: rtl/contador_sched.sv
// contador_sched: round-robin owner of a shared 4-bit contador.
// Two requesters (A, B) hand in {mode, load value, step count} through a
// valid/ready handshake. The scheduler drives the counter's ENB/MODO/D for
// the commanded number of enabled cycles. It then waits one cycle so the
// counter's registered Q/RCO settle, and reports the final Q plus a sticky
// "RCO was seen" flag in a one-cycle completion record.
module contador_sched #(
  parameter int STEP_W = 4
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              A_VALID,
  input  logic [1:0]        A_MODO,
  input  logic [3:0]        A_D,
  input  logic [STEP_W-1:0] A_STEPS,
  output logic              A_READY,
  input  logic              B_VALID,
  input  logic [1:0]        B_MODO,
  input  logic [3:0]        B_D,
  input  logic [STEP_W-1:0] B_STEPS,
  output logic              B_READY,
  output logic              CNT_ENB,
  output logic [1:0]        CNT_MODO,
  output logic [3:0]        CNT_D,
  input  logic [3:0]        CNT_Q,
  input  logic              CNT_RCO,
  output logic              DONE_VALID,
  output logic              DONE_ID,
  output logic [3:0]        DONE_Q,
  output logic              DONE_RCO
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;              // 0: A wins a tie, 1: B wins a tie
  logic              rcoseen_q, rcoseen_d;
  logic              enb_prev_q;              // CNT_ENB as it was one cycle ago
  logic              id_q, id_d;
  logic [STEP_W-1:0] left_q, left_d;          // enabled cycles still to issue
  logic              cnt_enb_q, cnt_enb_d;
  logic [1:0]        cnt_modo_q, cnt_modo_d;
  logic [3:0]        cnt_d_q, cnt_d_d;
  logic              done_valid_q, done_valid_d;
  logic              done_id_q, done_id_d;
  logic [3:0]        done_q_q, done_q_d;
  logic              done_rco_q, done_rco_d;

  logic              a_gnt, b_gnt, accept;
  logic [1:0]        sel_modo;
  logic [3:0]        sel_d;
  logic [STEP_W-1:0] sel_steps, eff_steps;

  // Grant decode, ready outputs and the command selected for latching
  always_comb begin
    a_gnt     = A_VALID & (~B_VALID | ~rr_q);
    b_gnt     = B_VALID & (~A_VALID | rr_q);
    accept    = (state_q == ST_IDLE) & (a_gnt | b_gnt);
    // RESET_L gating keeps READY low while reset is held, even though the
    // state register already sits in IDLE.
    A_READY   = RESET_L & (state_q == ST_IDLE) & a_gnt;
    B_READY   = RESET_L & (state_q == ST_IDLE) & b_gnt;
    sel_modo  = b_gnt ? B_MODO  : A_MODO;
    sel_d     = b_gnt ? B_D     : A_D;
    sel_steps = b_gnt ? B_STEPS : A_STEPS;
    // A parallel load is always exactly one enabled cycle.
    eff_steps = (sel_modo == 2'b11) ? STEP_W'(1) : sel_steps;
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    left_d       = left_q;
    rcoseen_d    = rcoseen_q | (enb_prev_q & CNT_RCO);
    cnt_enb_d    = cnt_enb_q;
    cnt_modo_d   = cnt_modo_q;
    cnt_d_d      = cnt_d_q;
    done_valid_d = 1'b0;
    done_id_d    = done_id_q;
    done_q_d     = done_q_q;
    done_rco_d   = done_rco_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d       = b_gnt;
          rr_d       = ~b_gnt;
          rcoseen_d  = 1'b0;
          cnt_modo_d = sel_modo;
          cnt_d_d    = sel_d;
          if (eff_steps == '0) begin
            // Nothing to run: report immediately with the untouched Q.
            state_d      = ST_DONE;
            done_valid_d = 1'b1;
            done_id_d    = b_gnt;
            done_q_d     = CNT_Q;
            done_rco_d   = 1'b0;
          end else begin
            state_d   = ST_RUN;
            cnt_enb_d = 1'b1;
            left_d    = eff_steps;
          end
        end
      end
      ST_RUN: begin
        if (left_q == STEP_W'(1)) begin
          state_d   = ST_WAIT;
          cnt_enb_d = 1'b0;
        end else begin
          left_d = left_q - STEP_W'(1);
        end
      end
      ST_WAIT: begin
        // Q/RCO now reflect the last enabled edge; rcoseen_d already folds
        // in this cycle's RCO sample.
        state_d      = ST_DONE;
        done_valid_d = 1'b1;
        done_id_d    = id_q;
        done_q_d     = CNT_Q;
        done_rco_d   = rcoseen_d;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q      <= ST_IDLE;
      rr_q         <= 1'b0;
      rcoseen_q    <= 1'b0;
      enb_prev_q   <= 1'b0;
      cnt_enb_q    <= 1'b0;
      cnt_modo_q   <= 2'b00;
      cnt_d_q      <= 4'h0;
      done_valid_q <= 1'b0;
      done_id_q    <= 1'b0;
      done_q_q     <= 4'h0;
      done_rco_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      rcoseen_q    <= rcoseen_d;
      enb_prev_q   <= cnt_enb_q;
      cnt_enb_q    <= cnt_enb_d;
      cnt_modo_q   <= cnt_modo_d;
      cnt_d_q      <= cnt_d_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_q_q     <= done_q_d;
      done_rco_q   <= done_rco_d;
    end
  end

  // Command bookkeeping; only meaningful after an accept, so no reset needed
  always_ff @(posedge CLK) begin
    id_q   <= id_d;
    left_q <= left_d;
  end

  assign CNT_ENB    = cnt_enb_q;
  assign CNT_MODO   = cnt_modo_q;
  assign CNT_D      = cnt_d_q;
  assign DONE_VALID = done_valid_q;
  assign DONE_ID    = done_id_q;
  assign DONE_Q     = done_q_q;
  assign DONE_RCO   = done_rco_q;

endmodule

// File: tb/tb_contador_sched.sv
// Bench for contador_sched: a behavioural contador sits on the counter
// side, a transaction-level model predicts every output cycle by cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_contador_sched;
  localparam int STEP_W = 4;

  logic              CLK = 1'b0;
  logic              RESET_L = 1'b0;
  logic              A_VALID = 1'b0, B_VALID = 1'b0;
  logic [1:0]        A_MODO = 2'b00, B_MODO = 2'b00;
  logic [3:0]        A_D = 4'h0, B_D = 4'h0;
  logic [STEP_W-1:0] A_STEPS = '0, B_STEPS = '0;
  logic              A_READY, B_READY;
  logic              CNT_ENB;
  logic [1:0]        CNT_MODO;
  logic [3:0]        CNT_D;
  logic [3:0]        CNT_Q;
  logic              CNT_RCO;
  logic              DONE_VALID, DONE_ID, DONE_RCO;
  logic [3:0]        DONE_Q;

  contador_sched #(.STEP_W(STEP_W)) dut (
    .CLK(CLK), .RESET_L(RESET_L),
    .A_VALID(A_VALID), .A_MODO(A_MODO), .A_D(A_D), .A_STEPS(A_STEPS), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_MODO(B_MODO), .B_D(B_D), .B_STEPS(B_STEPS), .B_READY(B_READY),
    .CNT_ENB(CNT_ENB), .CNT_MODO(CNT_MODO), .CNT_D(CNT_D), .CNT_Q(CNT_Q), .CNT_RCO(CNT_RCO),
    .DONE_VALID(DONE_VALID), .DONE_ID(DONE_ID), .DONE_Q(DONE_Q), .DONE_RCO(DONE_RCO)
  );

  always #5 CLK = ~CLK;

  // Behavioural contador: RCO flags a wrap (or any load); Q/RCO hold when disabled
  always @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      CNT_Q   <= 4'h0;
      CNT_RCO <= 1'b0;
    end else if (CNT_ENB) begin
      case (CNT_MODO)
        2'b00:   begin CNT_Q <= CNT_Q + 4'd1; CNT_RCO <= (CNT_Q == 4'd15); end
        2'b01:   begin CNT_Q <= CNT_Q - 4'd1; CNT_RCO <= (CNT_Q == 4'd0);  end
        2'b10:   begin CNT_Q <= CNT_Q - 4'd3; CNT_RCO <= (CNT_Q < 4'd3);   end
        default: begin CNT_Q <= CNT_D;        CNT_RCO <= 1'b1;             end
      endcase
    end
  end

  int total = 0, bad = 0, cyc = 0;
  // Model: schedule expressed as cycle numbers
  int m_free_at, m_enb_from, m_enb_to, m_done_at, m_q;
  bit m_rr;
  logic [1:0] m_modo;
  logic [3:0] m_d;
  bit p_id, p_rco, h_id, h_rco;
  logic [3:0] p_q, h_q;
  bit acc_a = 1'b0, acc_b = 1'b0;
  int acc_cyc = 0;
  // Observations of the DUT for the directed checks
  int done_cnt = 0, enb_cnt = 0, last_done_cyc = 0;
  logic [3:0] last_dq = 4'h0;
  bit last_did = 1'b0, last_drco = 1'b0, prev_enb = 1'b0;
  int gq[$];
  int qseq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_);
    total++;
    if (act !== exp_) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp_);
    end
  endtask

  task automatic model_reset();
    m_free_at = 0; m_enb_from = 0; m_enb_to = -1; m_done_at = -1;
    m_rr = 1'b0; m_modo = 2'b00; m_d = 4'h0; m_q = 0;
    h_id = 1'b0; h_q = 4'h0; h_rco = 1'b0;
  endtask

  task automatic model_accept(input bit id, input logic [1:0] mo, input logic [3:0] dd,
                              input logic [3:0] st);
    int n, nq;
    bit r;
    n = (mo == 2'b11) ? 1 : int'(st);
    case (mo)
      2'b00:   begin nq = m_q + n;     r = (nq > 15); end
      2'b01:   begin nq = m_q - n;     r = (nq < 0);  end
      2'b10:   begin nq = m_q - 3 * n; r = (nq < 0);  end
      default: begin nq = int'(dd);    r = 1'b1;      end
    endcase
    if (n == 0) r = 1'b0;
    nq = ((nq % 16) + 16) % 16;
    m_rr = !id; m_modo = mo; m_d = dd; acc_cyc = cyc;
    if (n == 0) begin
      m_done_at = cyc + 1; m_enb_from = 0; m_enb_to = -1;
    end else begin
      m_enb_from = cyc + 1; m_enb_to = cyc + n; m_done_at = cyc + n + 2;
    end
    m_free_at = m_done_at + 1;
    p_id = id; p_q = 4'(nq); p_rco = r; m_q = nq;
  endtask

  // Per-cycle comparison against the model, then record any handshake
  task automatic compare();
    bit idle, ea, eb, een, edv;
    if (RESET_L && cyc == m_done_at) begin h_id = p_id; h_q = p_q; h_rco = p_rco; end
    idle = RESET_L && (cyc >= m_free_at);
    ea   = idle && A_VALID && (!B_VALID || !m_rr);
    eb   = idle && B_VALID && (!A_VALID || m_rr);
    een  = RESET_L && (cyc >= m_enb_from) && (cyc <= m_enb_to);
    edv  = RESET_L && (cyc == m_done_at);
    chk("a_ready", 32'(A_READY), 32'(ea));
    chk("b_ready", 32'(B_READY), 32'(eb));
    chk("cnt_enb", 32'(CNT_ENB), 32'(een));
    if (een) begin
      chk("cnt_modo", 32'(CNT_MODO), 32'(m_modo));
      chk("cnt_d", 32'(CNT_D), 32'(m_d));
    end
    chk("done_valid", 32'(DONE_VALID), 32'(edv));
    chk("done_id", 32'(DONE_ID), 32'(h_id));
    chk("done_q", 32'(DONE_Q), 32'(h_q));
    chk("done_rco", 32'(DONE_RCO), 32'(h_rco));
    if (prev_enb) qseq.push_back(int'(CNT_Q));
    prev_enb = (CNT_ENB === 1'b1);
    if (CNT_ENB === 1'b1) enb_cnt++;
    if (DONE_VALID === 1'b1) begin
      done_cnt++; last_done_cyc = cyc; last_dq = DONE_Q; last_did = DONE_ID; last_drco = DONE_RCO;
    end
    if (A_VALID === 1'b1 && A_READY === 1'b1) gq.push_back(0);
    if (B_VALID === 1'b1 && B_READY === 1'b1) gq.push_back(1);
    acc_a = ea; acc_b = eb;
    if (eb) model_accept(1'b1, B_MODO, B_D, B_STEPS);
    else if (ea) model_accept(1'b0, A_MODO, A_D, A_STEPS);
  endtask

  task automatic tick();
    @(negedge CLK);
    compare();
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && cyc < m_free_at; i++) tick();
    chk("idle_timeout", 32'(cyc >= m_free_at), 1);
  endtask

  task automatic run_cmd(input bit id, input logic [1:0] mo, input logic [3:0] dd,
                         input logic [3:0] st);
    bit got;
    got = 1'b0;
    if (id) begin B_VALID = 1'b1; B_MODO = mo; B_D = dd; B_STEPS = st; end
    else    begin A_VALID = 1'b1; A_MODO = mo; A_D = dd; A_STEPS = st; end
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = id ? acc_b : acc_a;
    end
    chk("accept_timeout", 32'(got), 1);
    if (id) B_VALID = 1'b0; else A_VALID = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    RESET_L = 1'b0;
    model_reset();
    repeat (2) tick();
    RESET_L = 1'b1;
  endtask

  task automatic rnd_a();
    A_MODO = 2'($urandom_range(0, 3)); A_D = 4'($urandom_range(0, 15));
    A_STEPS = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
  endtask

  task automatic rnd_b();
    B_MODO = 2'($urandom_range(0, 3)); B_D = 4'($urandom_range(0, 15));
    B_STEPS = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0, ca, cb, dsave;
    bit got;
    int ex2[3] = '{15, 0, 1};
    model_reset();
    repeat (3) tick();
    RESET_L = 1'b1;
    repeat (2) tick();

    // Load 1110 from A
    e0 = enb_cnt; d0 = done_cnt;
    run_cmd(1'b0, 2'b11, 4'b1110, 4'd5);
    chk("tp1_lat", last_done_cyc - acc_cyc, 3);
    chk("tp1_q", 32'(last_dq), 14);
    chk("tp1_rco", 32'(last_drco), 1);
    chk("tp1_id", 32'(last_did), 0);
    chk("tp1_enb", enb_cnt - e0, 1);
    chk("tp1_ndone", done_cnt - d0, 1);

    // B counts up 3 across the wrap
    e0 = enb_cnt; qseq.delete();
    run_cmd(1'b1, 2'b00, 4'h0, 4'd3);
    chk("tp2_q", 32'(last_dq), 1);
    chk("tp2_rco", 32'(last_drco), 1);
    chk("tp2_id", 32'(last_did), 1);
    chk("tp2_enb", enb_cnt - e0, 3);
    chk("tp2_lat", last_done_cyc - acc_cyc, 5);
    chk("tp2_qn", qseq.size(), 3);
    for (int i = 0; i < 3; i++) chk("tp2_qseq", (i < qseq.size()) ? qseq[i] : 99, ex2[i]);

    // Load 0111, down-by-3 twice, then a zero-step command
    run_cmd(1'b0, 2'b11, 4'b0111, 4'd0);
    run_cmd(1'b0, 2'b10, 4'h0, 4'd2);
    chk("tp3_q", 32'(last_dq), 1);
    chk("tp3_rco", 32'(last_drco), 0);
    e0 = enb_cnt;
    run_cmd(1'b0, 2'b01, 4'h0, 4'd0);
    chk("tp3z_lat", last_done_cyc - acc_cyc, 1);
    chk("tp3z_q", 32'(last_dq), 1);
    chk("tp3z_rco", 32'(last_drco), 0);
    chk("tp3z_enb", enb_cnt - e0, 0);

    // Both valid after reset: strict alternation starting with A
    do_reset();
    gq.delete();
    A_VALID = 1'b1; A_MODO = 2'b00; A_D = 4'h0; A_STEPS = 4'd1;
    B_VALID = 1'b1; B_MODO = 2'b00; B_D = 4'h0; B_STEPS = 4'd1;
    for (int i = 0; i < 60 && gq.size() < 4; i++) tick();
    chk("tp4_grants", 32'(gq.size() >= 4), 1);
    for (int i = 0; i < 4; i++) chk("tp4_order", (i < gq.size()) ? gq[i] : 9, i % 2);
    A_VALID = 1'b0; B_VALID = 1'b0;
    wait_idle();

    // B waits with changing fields during A's run
    run_cmd(1'b0, 2'b11, 4'd5, 4'd0);
    A_VALID = 1'b1; A_MODO = 2'b00; A_D = 4'h0; A_STEPS = 4'd6;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = acc_a; end
    chk("tp5_acc_a", 32'(got), 1);
    ca = acc_cyc;
    A_VALID = 1'b0; B_VALID = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (cyc >= m_free_at) begin B_MODO = 2'b01; B_D = 4'd9; B_STEPS = 4'd2; end
      else rnd_b();
      tick();
      got = acc_b;
    end
    chk("tp5_acc_b", 32'(got), 1);
    cb = acc_cyc;
    B_VALID = 1'b0;
    wait_idle();
    chk("tp5_spacing", cb - ca, 9);
    chk("tp5_q", 32'(last_dq), 9);
    chk("tp5_id", 32'(last_did), 1);
    chk("tp5_rco", 32'(last_drco), 0);

    // Randomized traffic from both requesters
    acc_a = 1'b0; acc_b = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (acc_a || !A_VALID) begin
        if ($urandom_range(0, 2) != 0) begin A_VALID = 1'b1; rnd_a(); end
        else A_VALID = 1'b0;
      end else if ($urandom_range(0, 3) == 0) rnd_a();
      if (acc_b || !B_VALID) begin
        if ($urandom_range(0, 2) != 0) begin B_VALID = 1'b1; rnd_b(); end
        else B_VALID = 1'b0;
      end else if ($urandom_range(0, 3) == 0) rnd_b();
      tick();
    end
    A_VALID = 1'b0; B_VALID = 1'b0;
    wait_idle();

    // Reset pulse in the middle of a 10-step run
    A_VALID = 1'b1; A_MODO = 2'b00; A_D = 4'h0; A_STEPS = 4'd10;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = acc_a; end
    chk("tp6_acc", 32'(got), 1);
    A_VALID = 1'b0;
    repeat (4) tick();
    chk("tp6_enb_mid", 32'(CNT_ENB), 1);
    dsave = done_cnt;
    A_VALID = 1'b1; A_MODO = 2'b00; A_STEPS = 4'd1;
    #2 RESET_L = 1'b0;
    #1;
    chk("tp6_rst_enb", 32'(CNT_ENB), 0);
    chk("tp6_rst_modo", 32'(CNT_MODO), 0);
    chk("tp6_rst_d", 32'(CNT_D), 0);
    chk("tp6_rst_ready", 32'(A_READY), 0);
    chk("tp6_rst_dv", 32'(DONE_VALID), 0);
    chk("tp6_rst_dq", 32'(DONE_Q), 0);
    chk("tp6_rst_did", 32'(DONE_ID), 0);
    chk("tp6_rst_drco", 32'(DONE_RCO), 0);
    model_reset();
    repeat (2) tick();
    RESET_L = 1'b1;
    #1;
    chk("tp6_ready_rel", 32'(A_READY), 1);
    chk("tp6_no_done", done_cnt, dsave);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin tick(); got = acc_a; end
    chk("tp6_reacc", 32'(got), 1);
    A_VALID = 1'b0;
    wait_idle();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
